// File: rtl/ib_mem_responder_pkg.sv
// ib_mem_responder_pkg
//   Shared definitions for the internal-bus memory responder:
//   - data word and byte-enable widths
//   - write framing state encoding
//   - LFSR polynomial, seed and step function for the optional wait-state
//     generator (enabled with the IB_MEM_RESPONDER_WAIT_EN macro)
package ib_mem_responder_pkg;

  localparam int WORD_W = 64;
  localparam int BE_W   = 8;

  typedef enum logic {
    W_IDLE  = 1'b0,
    W_BURST = 1'b1
  } wr_state_t;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_POLY) : (cur >> 1);
  endfunction

endpackage

// File: rtl/ib_mem_rd_fifo.sv
// ib_mem_rd_fifo
//   Synchronous FIFO with occupancy count, used as the read-data output buffer.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     push, push_data   write side
//     pop, pop_data     read side (pop_data shows the head entry)
//     empty, count      status; count ranges 0..DEPTH
//   Parameters: WIDTH (entry width), DEPTH (power of 2, >= 2).
module ib_mem_rd_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_C = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_C);
  assign do_pop   = pop & ~empty;
  // a push into a full FIFO is only safe when the head leaves the same cycle
  assign do_push  = push & (~full | do_pop);
  assign pop_data = store[rd_ptr];

  // Pointer and count update; pointers wrap naturally since DEPTH is 2^PW
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; empty entries are never observed
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ib_mem_responder.sv
// ib_mem_responder
//   User-side target for the internal-bus endpoint: consumes write bursts and
//   read requests into a local 64-bit word memory and returns read data with a
//   source/destination ready handshake.
//   Ports:
//     CLK, RESET_N                       clock, asynchronous active-low reset
//     WR_ADDR/DATA/BE/REQ/LENGTH/SOF/EOF  write request interface
//     WR_RDY                             write accepted when high with WR_REQ
//     RD_ADDR/BE/REQ/SOF_IN/EOF_IN       read request interface
//     RD_ARDY                            read accepted when high with RD_REQ
//     RD_DATA, RD_SRC_RDY, RD_DST_RDY    read data output handshake
//     WR_ERR                             sticky write-framing error
//   Optional feature: define IB_MEM_RESPONDER_WAIT_EN to insert LFSR-driven
//   wait states on WR_RDY and RD_ARDY.
module ib_mem_responder
  import ib_mem_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH    = 10,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          RD_FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [31:0]       WR_ADDR,
  input  logic [WORD_W-1:0] WR_DATA,
  input  logic [BE_W-1:0]   WR_BE,
  input  logic              WR_REQ,
  output logic              WR_RDY,
  input  logic [11:0]       WR_LENGTH,
  input  logic              WR_SOF,
  input  logic              WR_EOF,
  input  logic [31:0]       RD_ADDR,
  input  logic [BE_W-1:0]   RD_BE,
  input  logic              RD_REQ,
  output logic              RD_ARDY,
  input  logic              RD_SOF_IN,
  input  logic              RD_EOF_IN,
  output logic [WORD_W-1:0] RD_DATA,
  output logic              RD_SRC_RDY,
  input  logic              RD_DST_RDY,
  output logic              WR_ERR
);

  localparam int          WORDS    = 1 << ADDR_WIDTH;
  localparam logic [31:0] WIN_MASK = 32'((64'd1 << (ADDR_WIDTH + 3)) - 64'd1);
  localparam int          CW       = $clog2(RD_FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C  = (CW+1)'(RD_FIFO_DEPTH);

  logic                  ready_q;
  logic                  wr_gate;
  logic                  rd_gate;
  logic                  wr_fire;
  logic                  wr_hit;
  logic                  rd_fire;
  logic                  rd_hit;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [ADDR_WIDTH-1:0] rd_idx;
  wr_state_t             wr_state_q;
  wr_state_t             wr_state_d;
  logic                  wr_err_q;
  logic                  wr_err_d;
  logic                  inflight_q;
  logic [WORD_W-1:0]     stage_data_q;
  logic [WORD_W-1:0]     rd_word;
  logic [WORD_W-1:0]     mem [WORDS];
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic [WORD_W-1:0]     fifo_data;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           credit_used;
  logic                  unused_inputs;

  // Framing/length/read byte-enable inputs carry no meaning for this target
  assign unused_inputs = ^{WR_LENGTH, RD_BE, RD_SOF_IN, RD_EOF_IN};

`ifdef IB_MEM_RESPONDER_WAIT_EN
  logic [15:0] lfsr_q;
  logic        unused_lfsr;

  // Free-running pseudo-random wait-state source
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_next(lfsr_q);
  end

  assign wr_gate     = lfsr_q[0];
  assign rd_gate     = lfsr_q[1];
  assign unused_lfsr = ^lfsr_q[15:2];
`else
  assign wr_gate = 1'b0;
  assign rd_gate = 1'b0;
`endif

  assign wr_hit  = (WR_ADDR & ~WIN_MASK) == BASE_ADDR;
  assign rd_hit  = (RD_ADDR & ~WIN_MASK) == BASE_ADDR;
  assign wr_idx  = WR_ADDR[ADDR_WIDTH+2:3];
  assign rd_idx  = RD_ADDR[ADDR_WIDTH+2:3];

  // Credits count both buffered words and the one in the memory stage, so an
  // accepted read always has a FIFO slot waiting for it
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};

  assign WR_RDY  = ready_q & ~wr_gate;
  assign RD_ARDY = ready_q & ~rd_gate & (credit_used < DEPTH_C);
  assign wr_fire = WR_REQ & WR_RDY;
  assign rd_fire = RD_REQ & RD_ARDY;
  assign WR_ERR  = wr_err_q;

  // Byte-masked memory write; out-of-window writes are dropped
  always_ff @(posedge CLK) begin
    if (wr_fire && wr_hit) begin
      for (int i = 0; i < BE_W; i++) begin
        if (WR_BE[i]) mem[wr_idx][8*i +: 8] <= WR_DATA[8*i +: 8];
      end
    end
  end

  // Write-first bypass: a same-cycle write to the read word is merged in
  always_comb begin
    rd_word = mem[rd_idx];
    if (wr_fire && wr_hit && (wr_idx == rd_idx)) begin
      for (int i = 0; i < BE_W; i++) begin
        if (WR_BE[i]) rd_word[8*i +: 8] = WR_DATA[8*i +: 8];
      end
    end
  end

  // Write framing next state; errors resynchronise on the offending SOF
  always_comb begin
    wr_state_d = wr_state_q;
    wr_err_d   = wr_err_q;
    if (wr_fire) begin
      case (wr_state_q)
        W_IDLE: begin
          if (!WR_SOF)      wr_err_d   = 1'b1;
          else if (!WR_EOF) wr_state_d = W_BURST;
        end
        W_BURST: begin
          if (WR_SOF) wr_err_d   = 1'b1;
          if (WR_EOF) wr_state_d = W_IDLE;
        end
        default: wr_state_d = W_IDLE;
      endcase
    end
  end

  // Control registers: ready enable, framing state, sticky error
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ready_q    <= 1'b0;
      wr_state_q <= W_IDLE;
      wr_err_q   <= 1'b0;
    end else begin
      ready_q    <= 1'b1;
      wr_state_q <= wr_state_d;
      wr_err_q   <= wr_err_d;
    end
  end

  // Registered memory read stage; misses return zero but still occupy a slot
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      inflight_q   <= 1'b0;
      stage_data_q <= '0;
    end else begin
      inflight_q <= rd_fire;
      if (rd_fire) stage_data_q <= rd_hit ? rd_word : '0;
    end
  end

  assign fifo_pop   = RD_SRC_RDY & RD_DST_RDY;
  assign RD_SRC_RDY = ~fifo_empty;
  assign RD_DATA    = fifo_empty ? '0 : fifo_data;

  ib_mem_rd_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (RD_FIFO_DEPTH)
  ) u_rd_fifo (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .push      (inflight_q),
    .push_data (stage_data_q),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_ib_mem_responder.sv
// tb_ib_mem_responder
//   Directed self-checking bench for ib_mem_responder (default build,
//   ADDR_WIDTH=10, BASE_ADDR=0, RD_FIFO_DEPTH=4).
module tb_ib_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic        wr_req;
  logic        wr_rdy;
  logic [11:0] wr_length;
  logic        wr_sof;
  logic        wr_eof;
  logic [31:0] rd_addr;
  logic [7:0]  rd_be;
  logic        rd_req;
  logic        rd_ardy;
  logic        rd_sof_in;
  logic        rd_eof_in;
  logic [63:0] rd_data;
  logic        rd_src_rdy;
  logic        rd_dst_rdy;
  logic        wr_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ib_mem_responder dut (
    .CLK        (clk),
    .RESET_N    (reset_n),
    .WR_ADDR    (wr_addr),
    .WR_DATA    (wr_data),
    .WR_BE      (wr_be),
    .WR_REQ     (wr_req),
    .WR_RDY     (wr_rdy),
    .WR_LENGTH  (wr_length),
    .WR_SOF     (wr_sof),
    .WR_EOF     (wr_eof),
    .RD_ADDR    (rd_addr),
    .RD_BE      (rd_be),
    .RD_REQ     (rd_req),
    .RD_ARDY    (rd_ardy),
    .RD_SOF_IN  (rd_sof_in),
    .RD_EOF_IN  (rd_eof_in),
    .RD_DATA    (rd_data),
    .RD_SRC_RDY (rd_src_rdy),
    .RD_DST_RDY (rd_dst_rdy),
    .WR_ERR     (wr_err)
  );

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present a write and/or a read in the same cycle and hold until accepted
  task automatic applyStimulus(input logic do_wr, input logic [31:0] wa,
                               input logic [63:0] wd, input logic [7:0] be,
                               input logic sof, input logic eof,
                               input logic do_rd, input logic [31:0] ra);
    bit done = 1'b0;
    wr_req  = do_wr;
    wr_addr = wa;
    wr_data = wd;
    wr_be   = be;
    wr_sof  = sof;
    wr_eof  = eof;
    rd_req  = do_rd;
    rd_addr = ra;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      done = (!do_wr || wr_rdy) && (!do_rd || rd_ardy);
      @(posedge clk);
      #1;
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    wr_sof = 1'b0;
    wr_eof = 1'b0;
    checkOutput("handshake_accepted", 64'(done), 64'd1);
  endtask

  task automatic writeWord(input logic [31:0] a, input logic [63:0] d,
                           input logic [7:0] be, input logic sof, input logic eof);
    applyStimulus(1'b1, a, d, be, sof, eof, 1'b0, 32'h0);
  endtask

  task automatic readWord(input logic [31:0] a);
    applyStimulus(1'b0, 32'h0, 64'h0, 8'h00, 1'b0, 1'b0, 1'b1, a);
  endtask

  // Wait for the next returned word (consumer ready) and check it
  task automatic expectWord(input string tag, input logic [63:0] exp);
    bit seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = rd_src_rdy;
    end
    checkOutput({tag, "_valid"}, 64'(seen), 64'd1);
    checkOutput({tag, "_data"}, rd_data, exp);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] burstWord(input int i);
    return {32'hCAFE_F00D, 32'(i * 3 + 1)};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int next_in;
    int next_out;
    int stray;
    bit acc;

    reset_n    = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    wr_be      = '0;
    wr_req     = 1'b0;
    wr_length  = 12'd8;
    wr_sof     = 1'b0;
    wr_eof     = 1'b0;
    rd_addr    = '0;
    rd_be      = 8'hFF;
    rd_req     = 1'b0;
    rd_sof_in  = 1'b0;
    rd_eof_in  = 1'b0;
    rd_dst_rdy = 1'b1;

    #1;
    checkOutput("reset_wr_rdy", 64'(wr_rdy), 64'd0);
    checkOutput("reset_rd_ardy", 64'(rd_ardy), 64'd0);
    checkOutput("reset_src_rdy", 64'(rd_src_rdy), 64'd0);
    checkOutput("reset_rd_data", rd_data, 64'h0);
    checkOutput("reset_wr_err", 64'(wr_err), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_wr_rdy", 64'(wr_rdy), 64'd1);
    checkOutput("post_reset_rd_ardy", 64'(rd_ardy), 64'd1);

    // 1: single-word write, read back with exact two-cycle latency
    writeWord(32'h10, 64'h1122334455667788, 8'hFF, 1'b1, 1'b1);
    readWord(32'h10);
    @(negedge clk);
    checkOutput("t1_lat1_src_rdy", 64'(rd_src_rdy), 64'd0);
    @(negedge clk);
    checkOutput("t1_lat2_src_rdy", 64'(rd_src_rdy), 64'd1);
    checkOutput("t1_data", rd_data, 64'h1122334455667788);
    @(posedge clk);
    #1;
    checkOutput("t1_wr_err", 64'(wr_err), 64'd0);

    // 2: partial byte-enable write
    writeWord(32'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, 1'b1);
    writeWord(32'h20, 64'h0, 8'h0F, 1'b1, 1'b1);
    readWord(32'h20);
    expectWord("t2_be_merge", 64'hFFFF_FFFF_0000_0000);

    // 3: back-pressure fills the buffer, then drains in order
    for (int i = 0; i < 8; i++) writeWord(32'h100 + 32'(8 * i), burstWord(i), 8'hFF, 1'b1, 1'b1);
    rd_dst_rdy = 1'b0;
    next_in    = 0;
    rd_addr    = 32'h100;
    rd_req     = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      acc = rd_ardy;
      @(posedge clk);
      #1;
      if (acc) begin
        next_in++;
        rd_addr = 32'h100 + 32'(8 * next_in);
      end
    end
    checkOutput("t3_accepted_while_stalled", 64'(next_in), 64'd4);
    @(negedge clk);
    checkOutput("t3_ardy_when_full", 64'(rd_ardy), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("t3_stall_src_rdy%0d", k), 64'(rd_src_rdy), 64'd1);
      checkOutput($sformatf("t3_stall_hold%0d", k), rd_data, burstWord(0));
    end
    @(posedge clk);
    #1;
    rd_dst_rdy = 1'b1;
    next_out   = 0;
    for (int c = 0; c < 60 && next_out < 8; c++) begin
      @(negedge clk);
      acc = rd_req && rd_ardy;
      if (rd_src_rdy) begin
        checkOutput($sformatf("t3_word%0d", next_out), rd_data, burstWord(next_out));
        next_out++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        next_in++;
        if (next_in < 8) rd_addr = 32'h100 + 32'(8 * next_in);
        else             rd_req  = 1'b0;
      end
    end
    rd_req = 1'b0;
    checkOutput("t3_all_returned", 64'(next_out), 64'd8);

    // 4: out-of-window read returns one zero word; write there is dropped
    writeWord(32'h0, 64'h0123456789ABCDEF, 8'hFF, 1'b1, 1'b1);
    readWord(32'h2000);
    expectWord("t4_miss", 64'h0);
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rd_src_rdy) stray++;
    end
    checkOutput("t4_single_word", 64'(stray), 64'd0);
    writeWord(32'h2000, 64'hBADB_ADBA_DBAD_BADB, 8'hFF, 1'b1, 1'b1);
    readWord(32'h0);
    expectWord("t4_word0_kept", 64'h0123456789ABCDEF);
    readWord(32'h10);
    expectWord("t4_word2_kept", 64'h1122334455667788);
    checkOutput("t4_wr_err", 64'(wr_err), 64'd0);

    // 5: write without SOF sets sticky error; later burst still lands
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    writeWord(32'h60, 64'h5555_5555_5555_5555, 8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t5_err_set", 64'(wr_err), 64'd1);
    writeWord(32'h80, 64'h0A0A_0A0A_0A0A_0A0A, 8'hFF, 1'b1, 1'b0);
    writeWord(32'h88, 64'h0B0B_0B0B_0B0B_0B0B, 8'hFF, 1'b0, 1'b0);
    writeWord(32'h90, 64'h0C0C_0C0C_0C0C_0C0C, 8'hFF, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t5_err_sticky", 64'(wr_err), 64'd1);
    readWord(32'h60);
    expectWord("t5_nosof_data", 64'h5555_5555_5555_5555);
    readWord(32'h80);
    expectWord("t5_burst0", 64'h0A0A_0A0A_0A0A_0A0A);
    readWord(32'h88);
    expectWord("t5_burst1", 64'h0B0B_0B0B_0B0B_0B0B);
    readWord(32'h90);
    expectWord("t5_burst2", 64'h0C0C_0C0C_0C0C_0C0C);

    // 6: write-first collision, then reset with buffered reads
    writeWord(32'h40, 64'h1111, 8'hFF, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h40, 64'hDEAD, 8'hFF, 1'b1, 1'b1, 1'b1, 32'h40);
    expectWord("t6_collision", 64'hDEAD);
    rd_dst_rdy = 1'b0;
    readWord(32'h80);
    readWord(32'h88);
    readWord(32'h90);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("t6_buffered", 64'(rd_src_rdy), 64'd1);
    checkOutput("t6_buffered_head", rd_data, 64'h0A0A_0A0A_0A0A_0A0A);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_reset_src_rdy", 64'(rd_src_rdy), 64'd0);
    checkOutput("t6_reset_rd_data", rd_data, 64'h0);
    checkOutput("t6_reset_rd_ardy", 64'(rd_ardy), 64'd0);
    checkOutput("t6_reset_wr_rdy", 64'(wr_rdy), 64'd0);
    checkOutput("t6_reset_wr_err", 64'(wr_err), 64'd0);
    @(negedge clk);
    reset_n    = 1'b1;
    rd_dst_rdy = 1'b1;
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rd_src_rdy) stray++;
    end
    checkOutput("t6_no_stale_words", 64'(stray), 64'd0);
    checkOutput("t6_wr_rdy_again", 64'(wr_rdy), 64'd1);
    readWord(32'h40);
    expectWord("t6_mem_kept", 64'hDEAD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ib_mem_responder.md
Name: ib_mem_responder

Overview:
- User-side responder for the internal-bus endpoint's write and read request interfaces.
- It is the far end of the endpoint's user bus: it consumes write bursts and read requests issued by the endpoint.
- It returns read data with a source/destination ready handshake.
- Backing store is a local 64-bit word memory. The block serves as a register/memory target in designs and as the reference target in endpoint benches.

Parameters:
- ADDR_WIDTH, 10, word-address bits; memory holds 2^ADDR_WIDTH 64-bit words.
- BASE_ADDR, 32'h0000_0000, byte base of the window; must be aligned to 8*2^ADDR_WIDTH.
- RD_FIFO_DEPTH, 4, read-data output buffer depth (power of 2, ≥2).

Ports:
- CLK  in  1  clock
- RESET_N  in  1  asynchronous active-low reset
- WR_ADDR  in  32  write byte address
- WR_DATA  in  64  write data
- WR_BE  in  8  write byte enables
- WR_REQ  in  1  write request
- WR_RDY  out  1  write accepted this cycle when high with WR_REQ
- WR_LENGTH  in  12  burst length in bytes, valid with WR_SOF
- WR_SOF  in  1  first word of write burst
- WR_EOF  in  1  last word of write burst
- RD_ADDR  in  32  read byte address
- RD_BE  in  8  read byte enables
- RD_REQ  in  1  read request
- RD_ARDY  out  1  read address accepted when high with RD_REQ
- RD_SOF_IN  in  1  first request of read burst
- RD_EOF_IN  in  1  last request of read burst
- RD_DATA  out  64  read data
- RD_SRC_RDY  out  1  RD_DATA valid
- RD_DST_RDY  in  1  consumer accepts RD_DATA
- WR_ERR  out  1  sticky write-framing error

Behaviour:
- Reset values (RESET_N=0, asynchronous): WR_RDY=0, RD_ARDY=0, RD_SRC_RDY=0, RD_DATA=0, WR_ERR=0. Read FIFO and in-flight stage are emptied; memory contents are not reset.
- Address decode:
  - hit = (ADDR & ~mask) == BASE_ADDR; word index = ADDR[ADDR_WIDTH+2:3]; ADDR[2:0] ignored.
- Write path:
  - WR_RDY=1 from the first clock after reset release (see optional feature).
  - Write fires on WR_REQ & WR_RDY. On a hit, each byte i with WR_BE[i]=1 is updated. On a miss, the write is dropped silently.
- Write framing FSM, states W_IDLE and W_BURST:
  - W_IDLE + fire + SOF + !EOF -> W_BURST.
  - SOF&EOF in W_IDLE: single-word burst, stays in W_IDLE.
  - W_BURST + fire + EOF -> W_IDLE.
  - Fire without SOF in W_IDLE, or with SOF in W_BURST: set WR_ERR (sticky until reset). The data is still written; the FSM resynchronises on the SOF.
  - WR_LENGTH is not checked.
- Read path:
  - Two-stage pipeline: a registered memory read, then an output FIFO.
  - RD_ARDY = (fifo_count + inflight) < RD_FIFO_DEPTH. This credit scheme means no overflow.
  - An accepted read at cycle t appears on RD_DATA/RD_SRC_RDY no earlier than t+2.
  - A miss returns 64'h0 and still produces exactly one data word.
  - RD_BE is ignored; full 64-bit words are always returned.
  - RD_SOF_IN/RD_EOF_IN are ignored for ordering; responses are strictly in request order.
- Read/write collision: a read and a write to the same word in the same cycle returns the new data (write-first).
- Output handshake:
  - A word transfers on RD_SRC_RDY & RD_DST_RDY.
  - RD_DATA is stable while RD_SRC_RDY=1 & RD_DST_RDY=0.
  - Throughput is 1 word/cycle with RD_DST_RDY held high.
- FIFO boundaries:
  - Full: RD_ARDY=0 until a word drains.
  - Simultaneous push and pop: count is unchanged.
  - Empty: RD_SRC_RDY=0.
  - Pointer wrap is modulo RD_FIFO_DEPTH.
- Reset mid-operation: in-flight and buffered reads are discarded. The FSM returns to W_IDLE.

Optional Feature:
- Macro IB_MEM_RESPONDER_WAIT_EN.
- Defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) inserts wait states.
  - WR_RDY is gated low when lfsr[0]=1.
  - RD_ARDY is additionally gated low when lfsr[1]=1.
  - All handshake rules still hold.
- Undefined: no LFSR; WR_RDY is constant 1 after reset and RD_ARDY depends on credits only.

Decomposition:
- Package ib_mem_responder_pkg:
  - word/BE width constants (64, 8);
  - write FSM state enum;
  - LFSR polynomial and seed constants.
- Sub-module ib_mem_rd_fifo: a synchronous FIFO with count output, parameterised by width and depth.

Test Plan:
1. Single write SOF&EOF to 0x10, data 64'h1122334455667788, BE 8'hFF; then a read of 0x10 with RD_DST_RDY=1 -> RD_DATA=64'h1122334455667788 at accept+2; WR_ERR=0.
2. Write 64'hFFFF_FFFF_FFFF_FFFF to 0x20, then 64'h0 with BE 8'h0F -> a read of 0x20 returns 64'hFFFF_FFFF_0000_0000.
3. Issue 8 back-to-back reads with RD_DST_RDY=0 -> exactly 4 accepted, then RD_ARDY=0. Release RD_DST_RDY -> all 8 words return in order, data held stable while stalled.
4. Read of address BASE_ADDR+8*2^ADDR_WIDTH -> one word of 64'h0. A write there leaves every in-window word unchanged.
5. Write without SOF after reset -> WR_ERR=1 and it stays 1. The following SOF..EOF burst is written correctly.
6. Same-cycle write and read to 0x40 with new data 64'hDEAD -> the read returns 64'hDEAD. Assert RESET_N=0 with 3 reads buffered -> RD_SRC_RDY=0 immediately, and no stale words appear after reset release.
